attn_softmax_row: RTL and testbench
===================================

// Module: attn_softmax_row
// PURPOSE
//  Row-wise base-2 softmax over one DIM x DIM tile of signed attention scores (Q*K^T from SA_wrapper).
//  Output is unsigned Q0.7 probabilities, which feed the P*V matmul pass of the attention block.
//  Row-serial, multi-cycle engine: captures the whole tile on I_START, then pulses O_DATA_VLD when the output tile is complete.
// PARAMETERS
//  D_W   8   element width. Scores are signed D_W; probabilities are unsigned D_W.
//  DIM   16  tile rows and columns (sequence length).
// PORTS
//  I_CLK        in   1             clock; all state changes on the rising edge
//  I_ASYN_RSTN  in   1             asynchronous active-low reset
//  I_SYNC_RSTN  in   1             synchronous active-low clear
//  I_START      in   1             start pulse; sampled only in IDLE
//  I_SCORE      in   [0:DIM-1][0:DIM-1][D_W]  signed score tile; captured on the I_START edge
//  O_BUSY       out  1             high from the cycle after start until the cycle DONE is left
//  O_DATA_VLD   out  1             one-cycle pulse; O_PROB is complete
//  O_PROB       out  [0:DIM-1][0:DIM-1][D_W]  probability tile; holds its value until the next start
// BEHAVIOUR
//  Reset (async, or sync on I_SYNC_RSTN=0): state=IDLE; O_BUSY=0; O_DATA_VLD=0; O_PROB all 0; internal registers 0. Sync clear mid-run aborts the run with the same result.
//  FSM: IDLE -> MAX -> EXPS -> RECIP -> NORM -> (next row ? MAX : DONE) -> IDLE.
//   IDLE : I_START=1 latches I_SCORE into the local tile, sets row=0, goes to MAX. I_START is ignored in every other state.
//   MAX  : DIM cycles, one column per cycle. m = signed max of the row.
//   EXPS : DIM cycles. d = m - x, as a 9-bit unsigned value.
//          e = (d>7) ? 0 : (8'd255 >> d). e is stored per column.
//          s = sum of e, 12-bit (max DIM*255 = 4080).
//   RECIP: exactly 16 cycles, restoring serial divide. r = floor(2^15 / s).
//          s >= 255 always (the max element gives e=255), so no divide-by-zero exists. r <= 128.
//   NORM : DIM cycles. O_PROB[row][c] = (e[c]*r) >> 8, 16-bit product, result <= 127.
//          Last NORM cycle: row++. If row==DIM, go to DONE; else go to MAX.
//   DONE : 1 cycle, O_DATA_VLD=1, then IDLE.
//  Latency: O_DATA_VLD is high exactly 1 + DIM*(3*DIM+16) cycles after the I_START edge (1025 for DIM=16).
//  O_PROB elements update only in NORM. Rows not yet processed keep their previous-run values.
//  I_START in the DONE cycle is ignored. I_START in the first IDLE cycle after DONE is accepted.
//  Signed compare throughout: -128 < 127. Ties for the max select the same m, so ties are harmless.
// TESTING
//  1. Every row = 0..15 (8'h00..8'h0f) -> s=502, r=65.
//     Per row, p[15..9] = 64,32,15,7,3,1,0; p[8..0] = 0.
//  2. Every element 8'h80 (all -128) -> s=4080, r=8, every p = 7.
//     O_DATA_VLD arrives at cycle 1025 after start.
//  3. Row = {100, others <= 92} -> p[0]=127, all other columns 0.
//     Also {127, -128 x15} gives the same result (d=255 -> e=0).
//  4. Second I_START pulse at cycles 5 and 600 of a run -> ignored.
//     Exactly one O_DATA_VLD pulse, at 1025.
//  5. I_SYNC_RSTN low for 1 cycle at cycle 300 -> IDLE, O_BUSY=0, O_PROB=0, no VLD pulse.
//     A restart then completes normally. Repeat the scenario with I_ASYN_RSTN asserted mid-cycle.
//  6. Back-to-back runs: start on the first IDLE cycle after DONE -> accepted.
//     O_PROB keeps the old tile until each row's NORM phase overwrites it.

Source files
------------

// File: rtl/attn_softmax_row.sv
// rtl/attn_softmax_row.sv - row-serial base-2 softmax over a DIM x DIM signed score tile
// Produces unsigned Q0.7 probabilities, one row at a time: max, exps, reciprocal, normalise.
module attn_softmax_row #(
   parameter int D_W = 8,
   parameter int DIM = 16
) (
   input  logic                             I_CLK,
   input  logic                             I_ASYN_RSTN,
   input  logic                             I_SYNC_RSTN,
   input  logic                             I_START,
   input  logic [0:DIM-1][0:DIM-1][D_W-1:0] I_SCORE,
   output logic                             O_BUSY,
   output logic                             O_DATA_VLD,
   output logic [0:DIM-1][0:DIM-1][D_W-1:0] O_PROB
);
   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int SW = D_W + CW;

   typedef enum logic [2:0] {IDLE, MAX, EXPS, RECIP, NORM, DONE} state_e;

   state_e                           state_q, state_d;
   logic [0:DIM-1][0:DIM-1][D_W-1:0] tile_q, tile_d, prob_q, prob_d;
   logic [0:DIM-1][D_W-1:0]          e_q, e_d;
   logic [CW-1:0]                    row_q, row_d, col_q, col_d;
   logic [3:0]                       rc_q, rc_d;
   logic [D_W-1:0]                   m_q, m_d, quo_q, quo_d;
   logic [SW-1:0]                    s_q, s_d, rem_q, rem_d;
   logic                             busy_q, busy_d, vld_q, vld_d;

   logic [D_W-1:0] x;
   logic [D_W:0]   diff;
   logic [D_W-1:0] e_val;
   logic [SW:0]    shifted;
   logic           last_col;

   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      prob_d  = prob_q;
      e_d     = e_q;
      row_d   = row_q;
      col_d   = col_q;
      rc_d    = rc_q;
      m_d     = m_q;
      quo_d   = quo_q;
      s_d     = s_q;
      rem_d   = rem_q;

      x        = tile_q[row_q][col_q];
      diff     = {m_q[D_W-1], m_q} - {x[D_W-1], x};
      e_val    = (diff > (D_W+1)'(D_W-1)) ? '0 : ({D_W{1'b1}} >> diff);
      shifted  = {rem_q, rc_q == 4'd0};
      last_col = (col_q == CW'(DIM-1));

      case (state_q)
         IDLE: begin
            if (I_START) begin
               tile_d  = I_SCORE;
               row_d   = '0;
               col_d   = '0;
               state_d = MAX;
            end
         end
         MAX: begin
            if (col_q == '0 || $signed(x) > $signed(m_q)) m_d = x;
            col_d = col_q + 1'b1;
            if (last_col) begin
               col_d   = '0;
               state_d = EXPS;
            end
         end
         EXPS: begin
            e_d[col_q] = e_val;
            s_d   = (col_q == '0) ? SW'(e_val) : s_q + SW'(e_val);
            col_d = col_q + 1'b1;
            if (last_col) begin
               col_d   = '0;
               rem_d   = '0;
               quo_d   = '0;
               rc_d    = '0;
               state_d = RECIP;
            end
         end
         RECIP: begin
            // Dividend is 2^15, so only the first step shifts in a 1. The quotient
            // never exceeds 128, so its upper bits are zero and an 8-bit register suffices.
            if (shifted >= {1'b0, s_q}) begin
               rem_d = SW'(shifted - {1'b0, s_q});
               quo_d = {quo_q[D_W-2:0], 1'b1};
            end else begin
               rem_d = shifted[SW-1:0];
               quo_d = {quo_q[D_W-2:0], 1'b0};
            end
            rc_d = rc_q + 4'd1;
            if (rc_q == 4'd15) state_d = NORM;
         end
         NORM: begin
            prob_d[row_q][col_q] = D_W'(((2*D_W)'(e_q[col_q]) * (2*D_W)'(quo_q)) >> D_W);
            col_d = col_q + 1'b1;
            if (last_col) begin
               col_d = '0;
               if (row_q == CW'(DIM-1)) begin
                  row_d   = '0;
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = MAX;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      vld_d  = (state_q == DONE);

      // Synchronous clear aborts any run and wipes all state, outputs included.
      if (!I_SYNC_RSTN) begin
         state_d = IDLE;
         tile_d  = '0;
         prob_d  = '0;
         e_d     = '0;
         row_d   = '0;
         col_d   = '0;
         rc_d    = '0;
         m_d     = '0;
         quo_d   = '0;
         s_d     = '0;
         rem_d   = '0;
         busy_d  = 1'b0;
         vld_d   = 1'b0;
      end
   end

   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         state_q <= IDLE;
         tile_q  <= '0;
         prob_q  <= '0;
         e_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         rc_q    <= '0;
         m_q     <= '0;
         quo_q   <= '0;
         s_q     <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         prob_q  <= prob_d;
         e_q     <= e_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rc_q    <= rc_d;
         m_q     <= m_d;
         quo_q   <= quo_d;
         s_q     <= s_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         vld_q   <= vld_d;
      end
   end

   assign O_BUSY     = busy_q;
   assign O_DATA_VLD = vld_q;
   assign O_PROB     = prob_q;

endmodule

// File: tb/tb_attn_softmax_row.sv
// tb/tb_attn_softmax_row.sv - directed table-driven bench for attn_softmax_row
module tb_attn_softmax_row;
   localparam int D_W = 8;
   localparam int DIM = 16;
   localparam int NV  = 8;
   localparam int LAT = 1025;

   typedef logic [0:DIM-1][D_W-1:0]          row_t;
   typedef logic [0:DIM-1][0:DIM-1][D_W-1:0] tile_t;
   typedef struct {
      row_t sc;
      row_t ex;
   } vec_t;

   logic  clk = 1'b0;
   logic  asyn_rstn = 1'b0;
   logic  sync_rstn = 1'b1;
   logic  start = 1'b0;
   tile_t score = '0;
   logic  busy, vld;
   tile_t prob;

   vec_t vecs[NV];
   int   total = 0;
   int   passed = 0;

   attn_softmax_row #(.D_W(D_W), .DIM(DIM)) dut (
      .I_CLK       (clk),
      .I_ASYN_RSTN (asyn_rstn),
      .I_SYNC_RSTN (sync_rstn),
      .I_START     (start),
      .I_SCORE     (score),
      .O_BUSY      (busy),
      .O_DATA_VLD  (vld),
      .O_PROB      (prob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic tile_t mk_tile(input int off);
      tile_t t;
      for (int r = 0; r < DIM; r++) t[r] = vecs[(r + off) % NV].sc;
      return t;
   endfunction

   function automatic row_t exp_row(input int off, input int r);
      return vecs[(r + off) % NV].ex;
   endfunction

   task automatic chk_row(input string tag, input int r, input row_t exp);
      chk($sformatf("%s_row%0d", tag, r), prob[r], exp);
   endtask

   task automatic do_start(input tile_t t);
      score = t;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_vld(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk); #1;
         if (vld) begin
            cyc = i;
            break;
         end
      end
   endtask

   initial begin
      int    cyc, nv, first;
      tile_t t80;

      for (int c = 0; c < DIM; c++) begin
         vecs[0].sc[c] = 8'(c);      vecs[0].ex[c] = 8'd0;
         vecs[1].sc[c] = 8'h80;      vecs[1].ex[c] = 8'd7;
         vecs[2].sc[c] = 8'd92;      vecs[2].ex[c] = 8'd0;
         vecs[3].sc[c] = 8'h80;      vecs[3].ex[c] = 8'd0;
         vecs[4].sc[c] = 8'(15 - c); vecs[4].ex[c] = 8'd0;
         vecs[5].sc[c] = 8'h9c;      vecs[5].ex[c] = 8'd0;
         vecs[6].sc[c] = 8'h00;      vecs[6].ex[c] = 8'd7;
         vecs[7].sc[c] = 8'h80;      vecs[7].ex[c] = 8'd0;
      end
      vecs[0].ex[15] = 8'd64; vecs[0].ex[14] = 8'd32; vecs[0].ex[13] = 8'd15;
      vecs[0].ex[12] = 8'd7;  vecs[0].ex[11] = 8'd3;  vecs[0].ex[10] = 8'd1;
      vecs[2].sc[0]  = 8'd100; vecs[2].ex[0] = 8'd127;
      vecs[3].sc[0]  = 8'd127; vecs[3].ex[0] = 8'd127;
      vecs[4].ex[0]  = 8'd64; vecs[4].ex[1] = 8'd32; vecs[4].ex[2] = 8'd15;
      vecs[4].ex[3]  = 8'd7;  vecs[4].ex[4] = 8'd3;  vecs[4].ex[5] = 8'd1;
      vecs[5].sc[0]  = 8'd5;  vecs[5].sc[1] = 8'd5;
      vecs[5].ex[0]  = 8'd63; vecs[5].ex[1] = 8'd63;
      vecs[7].sc[3]  = 8'hff; vecs[7].sc[7] = 8'hfe;
      vecs[7].ex[3]  = 8'd84; vecs[7].ex[7] = 8'd42;
      for (int r = 0; r < DIM; r++) t80[r] = vecs[1].sc;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_vld", 128'(vld), 128'(0));
      chk("rst_prob_zero", 128'(|prob), 128'(0));
      asyn_rstn = 1'b1;
      @(posedge clk); #1;

      // Table run: every vector appears in at least two rows
      do_start(mk_tile(0));
      chk("run_busy_after_start", 128'(busy), 128'(1));
      wait_vld(LAT + 50, cyc);
      chk("run_latency", 128'(cyc), 128'(LAT));
      chk("run_busy_in_vld", 128'(busy), 128'(0));
      for (int r = 0; r < DIM; r++) chk_row("table", r, exp_row(0, r));
      @(posedge clk); #1;
      chk("run_vld_one_cycle", 128'(vld), 128'(0));

      // Extra starts mid-run are ignored
      do_start(t80);
      nv = 0;
      first = -1;
      for (int i = 1; i <= LAT + 75; i++) begin
         if (i == 5 || i == 600) begin
            score = mk_tile(0);
            start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (vld) begin
            nv++;
            if (first < 0) first = i;
         end
      end
      chk("ign_vld_count", 128'(nv), 128'(1));
      chk("ign_vld_cycle", 128'(first), 128'(LAT));
      chk_row("ign", 0, vecs[1].ex);
      chk_row("ign", 15, vecs[1].ex);

      // Synchronous clear mid-run
      do_start(mk_tile(0));
      repeat (299) @(posedge clk);
      #1;
      sync_rstn = 1'b0;
      @(posedge clk); #1;
      sync_rstn = 1'b1;
      chk("sync_busy", 128'(busy), 128'(0));
      chk("sync_prob_zero", 128'(|prob), 128'(0));
      wait_vld(LAT + 50, cyc);
      chk("sync_no_vld", 128'(cyc), 128'(-1));
      do_start(mk_tile(0));
      wait_vld(LAT + 50, cyc);
      chk("sync_restart_latency", 128'(cyc), 128'(LAT));
      chk_row("sync_restart", 0, exp_row(0, 0));
      chk_row("sync_restart", 15, exp_row(0, 15));

      // Asynchronous reset mid-cycle
      do_start(mk_tile(0));
      repeat (299) @(posedge clk);
      #4;
      asyn_rstn = 1'b0;
      #1;
      chk("async_busy", 128'(busy), 128'(0));
      chk("async_vld", 128'(vld), 128'(0));
      chk("async_prob_zero", 128'(|prob), 128'(0));
      @(posedge clk); #1;
      asyn_rstn = 1'b1;
      @(posedge clk); #1;
      do_start(mk_tile(0));
      wait_vld(LAT + 50, cyc);
      chk("async_restart_latency", 128'(cyc), 128'(LAT));
      chk_row("async_restart", 7, exp_row(0, 7));

      // Start held through DONE (ignored) into the first IDLE cycle (accepted)
      @(posedge clk); #1;
      do_start(mk_tile(0));
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("b2b_done_no_vld_yet", 128'(vld), 128'(0));
      score = mk_tile(3);
      start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_vld", 128'(vld), 128'(1));
      chk("b2b_done_start_ignored", 128'(busy), 128'(0));
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_idle_start_accepted", 128'(busy), 128'(1));
      repeat (99) @(posedge clk);
      #1;
      chk_row("b2b_mid_new", 0, exp_row(3, 0));
      chk_row("b2b_mid_old", 1, exp_row(0, 1));
      chk_row("b2b_mid_old", 15, exp_row(0, 15));
      wait_vld(LAT, cyc);
      chk("b2b_latency", 128'(cyc), 128'(LAT - 99));
      for (int r = 0; r < DIM; r++) chk_row("b2b_final", r, exp_row(3, r));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
